uart_word_receiver: RTL and testbench
=====================================

UART_WORD_RECEIVER -- requirements
Module: uart_word_receiver

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 50000000, clk frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 115200, line bit rate in bit/s.
REQ-003 SHALL provide parameter TIMEOUT_BITS, default 32, inter-byte gap in bit times that abandons a partial word.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port RxD  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port dataOut  output  32  last fully assembled word.
REQ-008 SHALL have port dataValid  output  1  one-cycle pulse when dataOut is updated.
REQ-009 SHALL have port frameError  output  1  one-cycle pulse on bad stop bit.
REQ-010 SHALL have port busy  output  1  high while any byte or partial word is in progress.

Function
REQ-011 SHALL pass RxD through a 2-flop synchroniser (flops reset to 1); all decisions use the synchronised value.
REQ-012 SHALL generate an internal 16x oversample tick: one clk-wide pulse every DIV = CLK_FREQ/(BAUD*16) cycles (integer division), counter free-running.
REQ-013 SHALL use a byte FSM: IDLE, START, DATA, STOP.
REQ-014 IDLE -> START on synchronised RxD = 0 at an oversample tick; sample counter cleared.
REQ-015 START: at sample count 7 (mid-bit), RxD = 0 -> DATA with counter cleared; RxD = 1 -> IDLE (glitch, no output, no error).
REQ-016 DATA: sample every 16 ticks at mid-bit; 8 bits, LSB first, shifted into an 8-bit register; after bit 7 -> STOP.
REQ-017 STOP: mid-bit sample RxD = 1 -> byte accepted, FSM -> IDLE; a second stop bit is treated as idle line.
REQ-018 STOP: mid-bit sample RxD = 0 -> frameError pulse, byte discarded, byte counter and partial word cleared, FSM -> IDLE.
REQ-019 Accepted byte k (k = 0..3, 2-bit counter) SHALL be written to word bits [8k+7:8k]; first byte on the line is least significant.
REQ-020 On acceptance of byte 3: dataOut <= assembled word, dataValid = 1 for exactly one cycle, byte counter wraps to 0.
REQ-021 dataOut SHALL hold its value until the next complete word; partial words never appear on dataOut.
REQ-022 With byte counter != 0 and FSM in IDLE, a gap of TIMEOUT_BITS*16 oversample ticks with no start SHALL clear counter and partial word without error pulse.
REQ-023 dataValid and frameError SHALL never be high in the same cycle.
REQ-024 busy = (FSM != IDLE) OR (byte counter != 0).
REQ-025 Latency: dataValid asserts within 2 clk after the stop-bit mid-sample tick of byte 3.

Reset
REQ-026 rst_n low SHALL asynchronously force: FSM IDLE, counters 0, shift/partial word 0, dataOut = 0, dataValid = 0, frameError = 0, busy = 0, synchroniser flops = 1.
REQ-027 Reset mid-byte or mid-word SHALL discard all partial data; reception restarts at the next falling edge after release.
REQ-028 Reset release SHALL be taken synchronously to clk within the block (deassertion synchronised by 2 flops).

Verification
REQ-029 Send bytes EF, BE, AD, DE (8N2, nominal baud) -> dataOut = 0xDEADBEEF, one dataValid pulse, frameError never high.
REQ-030 Drive RxD low for 3 oversample ticks only -> no state beyond START, no pulses, busy returns to 0.
REQ-031 Send 0x11, then 0x22 with stop bit = 0, then 4 good bytes 01 02 03 04 -> one frameError pulse, then dataOut = 0x04030201.
REQ-032 Send 0xAA, 0xBB, wait 40 bit times, send 01 02 03 04 -> no pulse for the partial word, dataOut = 0x04030201.
REQ-033 Assert rst_n low during bit 4 of byte 2, release, send 4 bytes 10 20 30 40 -> dataOut = 0x40302010, single dataValid.
REQ-034 Send back-to-back words at baud +/-2% -> every word received correctly, dataValid once per word.

Source files
------------

// File: rtl/uart_word_receiver.sv
// uart_word_receiver
//   Receives 8N1/8N2 UART bytes and assembles four of them into a 32-bit
//   word. The first byte on the line lands in bits [7:0]. A bad stop bit
//   drops the partial word. A partial word is also dropped when the line
//   stays idle for TIMEOUT_BITS bit times.
//
// Ports
//   clk        : single clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset (deassertion re-synchronised)
//   RxD        : asynchronous serial line, idle high
//   dataOut    : last fully assembled word, held until the next word
//   dataValid  : one-cycle pulse when dataOut is updated
//   frameError : one-cycle pulse on a bad stop bit
//   busy       : high while a byte or a partial word is in progress
`timescale 1ns/1ps
module uart_word_receiver #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RxD,
  output logic [31:0] dataOut,
  output logic        dataValid,
  output logic        frameError,
  output logic        busy
);

  localparam int DIV_RAW   = CLK_FREQ / (BAUD * 16);
  localparam int DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_TICKS = TIMEOUT_BITS * 16;
  localparam int GAP_W     = $clog2(GAP_TICKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Reset asserts asynchronously. Its release is delayed through two flops
  // so that every other register leaves reset on a clean clock edge.
  logic [1:0] rst_pipe;
  logic       rst_s_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= '0;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_s_n = rst_pipe[1];

  // Two-flop synchroniser on the serial line. Both flops reset to idle (1).
  logic rx_meta, rx;

  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rx      <= rx_meta;
    end
  end

  // Free-running 16x oversample tick generator.
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  // Byte FSM and word assembly
  state_t           state, state_n;
  logic [3:0]       sample_cnt, sample_n;
  logic [2:0]       bit_cnt, bit_n;
  logic [7:0]       shreg, shreg_n;
  logic [1:0]       byte_cnt, byte_cnt_n;
  logic [31:0]      word, word_n;
  logic [GAP_W-1:0] gap_cnt, gap_n;
  logic [31:0]      dout_n;
  logic             valid_n, ferr_n;

  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      state      <= S_IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_cnt   <= '0;
      word       <= '0;
      gap_cnt    <= '0;
      dataOut    <= '0;
      dataValid  <= 1'b0;
      frameError <= 1'b0;
    end else begin
      state      <= state_n;
      sample_cnt <= sample_n;
      bit_cnt    <= bit_n;
      shreg      <= shreg_n;
      byte_cnt   <= byte_cnt_n;
      word       <= word_n;
      gap_cnt    <= gap_n;
      dataOut    <= dout_n;
      dataValid  <= valid_n;
      frameError <= ferr_n;
    end
  end

  always_comb begin
    state_n    = state;
    sample_n   = sample_cnt;
    bit_n      = bit_cnt;
    shreg_n    = shreg;
    byte_cnt_n = byte_cnt;
    word_n     = word;
    gap_n      = gap_cnt;
    dout_n     = dataOut;
    valid_n    = 1'b0;
    ferr_n     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (tick) begin
          if (!rx) begin
            state_n  = S_START;
            sample_n = '0;
            gap_n    = '0;
          end else if (byte_cnt != 2'd0) begin
            // Inter-byte gap watchdog: silently drop the partial word.
            if (gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
              gap_n      = '0;
              byte_cnt_n = '0;
              word_n     = '0;
            end else begin
              gap_n = gap_cnt + GAP_W'(1);
            end
          end
        end
      end

      S_START: begin
        if (tick) begin
          if (sample_cnt == 4'd7) begin
            if (!rx) begin
              state_n  = S_DATA;
              sample_n = '0;
              bit_n    = '0;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            sample_n = sample_cnt + 4'd1;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          // The 4-bit counter wraps, so every 16th tick lands at mid-bit.
          sample_n = sample_cnt + 4'd1;
          if (sample_cnt == 4'd15) begin
            shreg_n = {rx, shreg[7:1]};
            bit_n   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_n = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (tick) begin
          sample_n = sample_cnt + 4'd1;
          if (sample_cnt == 4'd15) begin
            state_n = S_IDLE;
            gap_n   = '0;
            if (rx) begin
              if (byte_cnt == 2'd3) begin
                dout_n     = {shreg, word[23:0]};
                valid_n    = 1'b1;
                word_n     = '0;
                byte_cnt_n = '0;
              end else begin
                word_n[{byte_cnt, 3'b000} +: 8] = shreg;
                byte_cnt_n = byte_cnt + 2'd1;
              end
            end else begin
              ferr_n     = 1'b1;
              word_n     = '0;
              byte_cnt_n = '0;
            end
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE) || (byte_cnt != 2'd0);

endmodule

// File: tb/tb_uart_word_receiver.sv
`timescale 1ns/1ps
module tb_uart_word_receiver;

  // 640 kHz clock with 10 kbaud gives DIV = 4 and 64 clocks per bit.
  localparam int  CLK_FREQ = 640000;
  localparam int  BAUD     = 10000;
  localparam int  TOB      = 32;
  localparam real BIT_NS   = 6400.0 / 10.0;   // 64 clocks of 10 ns

  logic        clk, rst_n, rxd;
  logic [31:0] dataOut;
  logic        dataValid, frameError, busy;

  uart_word_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst_n(rst_n), .RxD(rxd),
    .dataOut(dataOut), .dataValid(dataValid), .frameError(frameError), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Output monitor
  int          valid_cnt = 0, ferr_cnt = 0, overlap_cnt = 0;
  logic [31:0] got_q[$];

  always @(negedge clk) begin
    if (dataValid) begin
      valid_cnt++;
      got_q.push_back(dataOut);
    end
    if (frameError) ferr_cnt++;
    if (dataValid && frameError) overlap_cnt++;
  end

  // Reference model: a list of received bytes, flushed into a word every
  // fourth good byte, emptied on a bad stop bit or a long idle gap.
  logic [7:0]  m_bytes[$];
  logic [31:0] m_words[$];
  int          m_ferr;

  function automatic void m_reset();
    m_bytes.delete();
    m_words.delete();
    m_ferr = 0;
  endfunction

  function automatic void m_byte(input logic [7:0] b, input logic ok);
    logic [31:0] w;
    if (!ok) begin
      m_ferr++;
      m_bytes.delete();
    end else begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 4) begin
        w = 0;
        for (int k = 0; k < 4; k++) w += 32'(m_bytes[k]) * (32'd1 << (8 * k));
        m_words.push_back(w);
        m_bytes.delete();
      end
    end
  endfunction

  // Serial driver: start bit, 8 data bits LSB first, stop bit, second stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input real bit_ns);
    rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_ns);
    end
    rxd = stop_ok;
    #(bit_ns);
    rxd = 1'b1;
    #(bit_ns);
  endtask

  task automatic tx(input logic [7:0] b, input logic ok, input real bit_ns);
    send_byte(b, ok, bit_ns);
    m_byte(b, ok);
  endtask

  task automatic wait_idle(input string name, input int max_clk);
    int n = 0;
    while (busy && n < max_clk) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic compare_model(input string name, input int f0);
    check({name, "_nwords"}, got_q.size(), m_words.size());
    for (int i = 0; i < m_words.size() && i < got_q.size(); i++)
      check({name, "_word"}, got_q[i], m_words[i]);
    check({name, "_ferr"}, ferr_cnt - f0, m_ferr);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [3:0]  stop_ok;
    int          exp_valid;
    int          exp_ferr;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, f0;
    logic [7:0] b;
    rst_n = 1'b0;
    rxd   = 1'b1;
    #50;
    check("reset_dataOut",    dataOut, 32'd0);
    check("reset_dataValid",  {31'd0, dataValid}, 32'd0);
    check("reset_frameError", {31'd0, frameError}, 32'd0);
    check("reset_busy",       {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    vecs[0] = '{32'hDEADBEEF, 4'b1111, 1, 0, 32'hDEADBEEF};
    vecs[1] = '{32'h04030201, 4'b1111, 1, 0, 32'h04030201};
    vecs[2] = '{32'h00000000, 4'b1111, 1, 0, 32'h00000000};
    vecs[3] = '{32'hFFFFFFFF, 4'b1111, 1, 0, 32'hFFFFFFFF};
    vecs[4] = '{32'h12345678, 4'b1011, 0, 1, 32'hFFFFFFFF};
    vecs[5] = '{32'hA5A55A5A, 4'b1111, 1, 0, 32'hA5A55A5A};

    foreach (vecs[r]) begin
      logic [31:0] w;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      w  = vecs[r].word;
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], vecs[r].stop_ok[k], BIT_NS);
      wait_idle("vec_idle", 4000);
      check("vec_valid", valid_cnt - v0, vecs[r].exp_valid);
      check("vec_ferr",  ferr_cnt - f0,  vecs[r].exp_ferr);
      check("vec_out",   dataOut,        vecs[r].exp_out);
    end

    // Nominal word EF BE AD DE
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'hEF, 1'b1, BIT_NS); send_byte(8'hBE, 1'b1, BIT_NS);
    send_byte(8'hAD, 1'b1, BIT_NS); send_byte(8'hDE, 1'b1, BIT_NS);
    check("deadbeef_out",   dataOut, 32'hDEADBEEF);
    check("deadbeef_valid", valid_cnt - v0, 1);
    check("deadbeef_ferr",  ferr_cnt - f0, 0);

    // Short low glitch: rejected at the mid-start sample
    v0 = valid_cnt; f0 = ferr_cnt;
    @(negedge clk);
    rxd = 1'b0;
    #110;
    check("glitch_busy_seen", {31'd0, busy}, 32'd1);
    #10;
    rxd = 1'b1;
    #2000;
    check("glitch_busy_end", {31'd0, busy}, 32'd0);
    check("glitch_pulses", (valid_cnt - v0) + (ferr_cnt - f0), 0);

    // Partial word abandoned by an idle gap
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'hAA, 1'b1, BIT_NS); send_byte(8'hBB, 1'b1, BIT_NS);
    check("gap_busy_partial", {31'd0, busy}, 32'd1);
    #(BIT_NS * 40);
    check("gap_busy_cleared", {31'd0, busy}, 32'd0);
    check("gap_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b1, BIT_NS);
    check("gap_out",   dataOut, 32'h04030201);
    check("gap_valid", valid_cnt - v0, 1);

    // Reset during bit 4 of the third byte
    send_byte(8'h55, 1'b1, BIT_NS); send_byte(8'h66, 1'b1, BIT_NS);
    b = 8'h77;
    rxd = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      #(BIT_NS);
    end
    rxd = b[4];
    #(BIT_NS / 2);
    rst_n = 1'b0;
    #1;
    check("midrst_dataOut", dataOut, 32'd0);
    check("midrst_busy",    {31'd0, busy}, 32'd0);
    #100;
    rxd = 1'b1;
    rst_n = 1'b1;
    #(BIT_NS * 12);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'h10, 1'b1, BIT_NS); send_byte(8'h20, 1'b1, BIT_NS);
    send_byte(8'h30, 1'b1, BIT_NS); send_byte(8'h40, 1'b1, BIT_NS);
    check("midrst_out",   dataOut, 32'h40302010);
    check("midrst_valid", valid_cnt - v0, 1);

    // Bad stop bit in the middle of a stream
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'h11, 1'b1, BIT_NS); send_byte(8'h22, 1'b0, BIT_NS);
    for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b1, BIT_NS);
    check("badstop_ferr",  ferr_cnt - f0, 1);
    check("badstop_valid", valid_cnt - v0, 1);
    check("badstop_out",   dataOut, 32'h04030201);

    // Back-to-back random words at +2 % and -2 % baud
    for (int s = 0; s < 2; s++) begin
      real bn;
      bn = (s == 0) ? BIT_NS / 1.02 : BIT_NS / 0.98;
      m_reset(); got_q.delete(); f0 = ferr_cnt;
      for (int k = 0; k < 8; k++) tx(8'($urandom_range(0, 255)), 1'b1, bn);
      compare_model((s == 0) ? "fast" : "slow", f0);
    end

    // Random bytes with occasional bad stop bits, then an idle gap
    m_reset(); got_q.delete(); f0 = ferr_cnt;
    for (int k = 0; k < 14; k++)
      tx(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), BIT_NS);
    #(BIT_NS * 40);
    m_bytes.delete();
    check("rand_idle", {31'd0, busy}, 32'd0);
    compare_model("rand", f0);
    if (m_words.size() > 0) check("rand_last_out", dataOut, m_words[m_words.size() - 1]);

    check("never_both_pulses", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
